// File: rtl/tdm_pkg.sv
// Shared definitions for the 8:1 TDM link, used by both the transmitter and the receiver.
package tdm_pkg;

  localparam int TDM_N_CH  = 8;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM receiver: wraps at the last slot, can jump to
// slot 1 when a frame marker arrives, and can be cleared when lock is lost.
module tdm_slot_ctr #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             en,
  output logic [SEL_W-1:0] slot
);

  // clr and load1 take priority over advancing; the wrap relies on the
  // slot count being a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SEL_W'(1);
    end else if (en) begin
      slot <= slot + SEL_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_8ch.sv
// Receive end of the TDM link: steers serial bits into channel slots, publishes
// complete frames, and tracks frame lock and framing errors.
module tdm_demux_8ch
  import tdm_pkg::*;
#(
  parameter  int N_CH  = TDM_N_CH,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 frame,
  output logic [N_CH-1:0]      dout,
  output logic                 dout_valid,
  output logic [SEL_W-1:0]     slot,
  output logic                 locked,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  tdm_state_e      state;
  logic [N_CH-1:0] shadow;

  logic start;
  logic store;
  logic last;
  logic lose;
  logic err_evt;

  // A marker always begins a frame at slot 0, whether hunting or locked.
  always_comb begin
    start   = 1'b0;
    store   = 1'b0;
    last    = 1'b0;
    lose    = 1'b0;
    err_evt = 1'b0;
    if (din_valid) begin
      start = frame;
      if (state == RECV) begin
        store   = !frame && (slot != '0);
        last    = store && (slot == SEL_W'(N_CH - 1));
        lose    = !frame && (slot == '0);
        err_evt = frame ? (slot != '0) : (slot == '0);
      end
    end
  end

  tdm_slot_ctr #(
    .SEL_W(SEL_W)
  ) u_slot_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (lose),
    .load1(start),
    .en   (store),
    .slot (slot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HUNT;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      dout_valid <= last;
      frame_err  <= err_evt;
      if (start) begin
        state     <= RECV;
        shadow[0] <= din;
      end else if (lose) begin
        state <= HUNT;
      end
      if (store) begin
        shadow[slot] <= din;
      end
      // The final bit bypasses the shadow so the frame is published on the same edge.
      if (last) begin
        dout <= {din, shadow[N_CH-2:0]};
      end
      if (err_evt && (err_cnt != {ERR_CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign locked = (state == RECV);

endmodule

// File: doc/tdm_demux_8ch.md
# tdm_demux_8ch

Receive end of the 8:1 time-division mux link. Accepts one serial bit per cycle, tagged with a frame marker on slot 0. Steers each bit to its channel slot (slot 0 = channel A … slot 7 = channel H) and presents the complete frame as a registered parallel word with a one-cycle valid pulse. Detects framing loss, counts framing errors, and resynchronises automatically.

## Interface
Parameters:
- N_CH, 8, number of channels/slots; power of two, 2..16
- SEL_W, $clog2(N_CH), slot index width (derived; not overridden)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- din  in  1  serial data bit (mux output Z)
- din_valid  in  1  din/frame qualify this cycle
- frame  in  1  high with the slot-0 bit of each frame; ignored when din_valid=0
- dout  out  N_CH  last complete frame; dout[k] = slot k
- dout_valid  out  1  one-cycle pulse, dout updated this cycle
- slot  out  SEL_W  slot index expected for next accepted bit
- locked  out  1  high in RECV state
- frame_err  out  1  one-cycle pulse on framing violation
- err_cnt  out  8  framing errors since reset, saturates at 255

## Operation
- Accepted bit: din_valid=1 at a rising edge. Cycles with din_valid=0 stall everything; partial frame, slot and state hold.
- States: HUNT (no frame lock), RECV (locked).
- HUNT: accepted bit with frame=0 dropped, no error. Accepted bit with frame=1 stored as slot 0 → RECV, slot=1.
- RECV, slot≠0, frame=0: store din at shadow[slot], slot+1.
- RECV, slot=N_CH-1, frame=0: final bit; dout ← shadow with din in bit N_CH-1, dout_valid pulse, slot wraps to 0, stay RECV.
- RECV, slot=0, frame=1: normal frame start; store slot 0, slot=1.
- RECV, slot≠0, frame=1 (early marker): frame_err pulse, err_cnt+1, partial frame discarded, this bit taken as slot 0, slot=1, stay RECV. dout unchanged.
- RECV, slot=0, frame=0 (missing marker): frame_err pulse, err_cnt+1, bit dropped → HUNT, slot=0.
- Shadow register is internal; dout changes only on completed frames.
- err_cnt saturating: at 255 further errors still pulse frame_err, count holds.

## Timing
- Reset values: dout=0, dout_valid=0, slot=0, locked=0, frame_err=0, err_cnt=0, state HUNT, shadow=0.
- All outputs registered; no combinational path input→output.
- Latency: dout/dout_valid update at the edge that accepts the slot N_CH-1 bit; visible the following cycle.
- Back-to-back frames with din_valid held high: dout_valid pulses once every N_CH cycles.
- frame_err asserted in the cycle after the offending edge, for exactly one cycle.
- Reset mid-frame: partial frame discarded, all outputs to reset values at that edge; rst_n has priority over every input.
- slot/locked reflect post-edge state.

## Structure
- Shared package tdm_pkg: N_CH default, state enum (HUNT, RECV), ERR_CNT_W=8. Same package is used by the matching transmitter.
- One natural sub-module: tdm_slot_ctr (SEL_W-bit slot counter with wrap, load-1 and clear inputs).
- Top holds FSM, shadow register, output register, error counter.

## Test plan
- Reset, then frame=1 on first bit, bits 1,0,1,1,0,0,1,0 (slots 0..7) with din_valid high → dout=8'b0100_1101, one dout_valid pulse, locked=1, err_cnt=0.
- Two consecutive frames 8'hA5 then 8'h3C, no gaps → dout_valid pulses 8 cycles apart, dout=8'hA5 then 8'h3C.
- Same frame with din_valid low for 3 cycles between slots 3 and 4 → identical dout; dout_valid delayed 3 cycles; slot holds 4 during stall.
- frame=1 on slot 5 mid-frame → frame_err pulse, err_cnt=1, slot=1 next, dout unchanged until 7 more bits complete the new frame.
- Locked, frame=0 at slot 0 → frame_err, err_cnt+1, locked=0. Further bits without frame dropped; next frame=1 relocks.
- rst_n low at slot 4, then full frame 8'hFF → outputs clear on reset, dout=8'hFF after 8 accepted bits. 300 early-marker errors → err_cnt=255.
